// File: rtl/apb_spi_pkg.sv
// Shared register map and field positions for the APB SPI FIFO block.
// All addresses are APB word indices.
package apb_spi_pkg;

    localparam logic [3:0] ADDR_TXDATA   = 4'd0;
    localparam logic [3:0] ADDR_RXDATA   = 4'd1;
    localparam logic [3:0] ADDR_STATUS   = 4'd2;
    localparam logic [3:0] ADDR_CTRL     = 4'd3;
    localparam logic [3:0] ADDR_IRQ_STAT = 4'd4;
    localparam logic [3:0] ADDR_IRQ_EN   = 4'd5;

    localparam int ST_TX_CNT_LSB = 0;
    localparam int ST_RX_CNT_LSB = 8;
    localparam int ST_CNT_W      = 8;
    localparam int ST_TX_EMPTY   = 16;
    localparam int ST_TX_FULL    = 17;
    localparam int ST_RX_EMPTY   = 18;
    localparam int ST_RX_FULL    = 19;
    localparam int ST_BUSY       = 20;

    localparam int CT_EN      = 0;
    localparam int CT_TXCLR   = 1;
    localparam int CT_RXCLR   = 2;
    localparam int CT_DIV_LSB = 16;
    localparam int DIV_W      = 16;

    localparam int IRQ_TXEMPTY = 0;
    localparam int IRQ_RXWM    = 1;
    localparam int IRQ_EOT     = 2;
    localparam int IRQ_TXOVF   = 3;
    localparam int IRQ_RXUDF   = 4;
    localparam int IRQ_W       = 5;

endpackage

// File: rtl/apb_spi_rf_fifo_if.sv
// APB slave bus plus TX/RX stream handshakes of the SPI FIFO block.
// master = bus/stream environment, slave = the register file.
interface apb_spi_rf_fifo_if #(
    parameter int DW = 32
);
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [3:0]    paddr;
    logic [31:0]   pwdata;
    logic [31:0]   prdata;
    logic          pready;
    logic [DW-1:0] tx_data;
    logic          tx_vld;
    logic          tx_rdy;
    logic [DW-1:0] rx_data;
    logic          rx_vld;
    logic          rx_rdy;

    modport master (
        output psel, penable, pwrite, paddr, pwdata, tx_rdy, rx_data, rx_vld,
        input  prdata, pready, tx_data, tx_vld, rx_rdy
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata, tx_rdy, rx_data, rx_vld,
        output prdata, pready, tx_data, tx_vld, rx_rdy
    );
endinterface

// File: rtl/spi_sync_fifo.sv
// Single-clock FIFO; full/empty come from the occupancy count.
// Flush and reset empty it and take priority over push/pop.
module spi_sync_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);
    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) wp <= wp + 1'b1;
            if (do_pop)  rp <= rp + 1'b1;
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wp] <= din;
    end
endmodule

// File: rtl/apb_spi_rf_fifo.sv
// APB register file fronting TX/RX stream FIFOs of an SPI master,
// with divider update strobe and sticky interrupt status.
module apb_spi_rf_fifo
    import apb_spi_pkg::*;
#(
    parameter int DW       = 32,
    parameter int TX_DEPTH = 8,
    parameter int RX_DEPTH = 8,
    parameter int MIN_DIV  = 4
) (
    input  logic          pclk_i,
    input  logic          rst_i,
    input  logic          psel_i,
    input  logic          penable_i,
    input  logic          pwrite_i,
    input  logic [3:0]    paddr_i,
    input  logic [31:0]   pwdata_i,
    output logic [31:0]   prdata_o,
    output logic          pready_o,
    output logic          spi_clk_div_vld_o,
    output logic [15:0]   spi_clk_div_o,
    input  logic          eot_i,
    output logic [DW-1:0] stream_data_tx_o,
    output logic          stream_data_tx_vld_o,
    input  logic          stream_data_tx_rdy_i,
    input  logic [DW-1:0] stream_data_rx_i,
    input  logic          stream_data_rx_vld_i,
    output logic          stream_data_rx_rdy_o,
    output logic          irq_o
);
    localparam int TXCW = $clog2(TX_DEPTH) + 1;
    localparam int RXCW = $clog2(RX_DEPTH) + 1;
    localparam logic [DIV_W-1:0] MIN_DIV16 = DIV_W'(MIN_DIV);

    logic             wr, rd, ctrl_wr;
    logic             en_q, div_vld_q, irq_q, pend_q;
    logic [DIV_W-1:0] div_q, wdiv;
    logic [IRQ_W-1:0] stat_q, stat_d, irq_en_q, irq_en_d, ev, clr;
    logic             tx_push, tx_pop, tx_flush, tx_full, tx_empty;
    logic             rx_push, rx_pop, rx_flush, rx_full, rx_empty;
    logic [DW-1:0]    rx_dout;
    logic [TXCW-1:0]  tx_count;
    logic [RXCW-1:0]  rx_count;
    logic [31:0]      status, rdata;

    assign wr       = psel_i & penable_i & pwrite_i;
    assign rd       = psel_i & penable_i & ~pwrite_i;
    assign ctrl_wr  = wr & (paddr_i == ADDR_CTRL);
    assign wdiv     = pwdata_i[CT_DIV_LSB +: DIV_W];
    assign tx_flush = ctrl_wr & pwdata_i[CT_TXCLR];
    assign rx_flush = ctrl_wr & pwdata_i[CT_RXCLR];

    assign tx_push = wr & (paddr_i == ADDR_TXDATA) & ~tx_full;
    assign tx_pop  = stream_data_tx_vld_o & stream_data_tx_rdy_i;
    assign rx_push = stream_data_rx_vld_i & stream_data_rx_rdy_o;
    assign rx_pop  = rd & (paddr_i == ADDR_RXDATA) & ~rx_empty;

    assign stream_data_tx_vld_o = en_q & ~tx_empty;
    assign stream_data_rx_rdy_o = en_q & ~rx_full;

    spi_sync_fifo #(.DW(DW), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk(pclk_i), .rst(rst_i), .push(tx_push), .pop(tx_pop),
        .flush(tx_flush), .din(pwdata_i[DW-1:0]), .dout(stream_data_tx_o),
        .full(tx_full), .empty(tx_empty), .count(tx_count)
    );

    spi_sync_fifo #(.DW(DW), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(pclk_i), .rst(rst_i), .push(rx_push), .pop(rx_pop),
        .flush(rx_flush), .din(stream_data_rx_i), .dout(rx_dout),
        .full(rx_full), .empty(rx_empty), .count(rx_count)
    );

    // Set events are OR-ed after the W1C mask so a same-cycle set survives
    always_comb begin
        ev              = '0;
        ev[IRQ_TXEMPTY] = tx_pop & ~tx_push & ~tx_flush
                          & (tx_count == TXCW'(1));
        ev[IRQ_RXWM]    = rx_push & ~rx_pop & ~rx_flush
                          & (rx_count == RXCW'(RX_DEPTH / 2 - 1));
        ev[IRQ_EOT]     = eot_i;
        ev[IRQ_TXOVF]   = wr & (paddr_i == ADDR_TXDATA) & tx_full;
        ev[IRQ_RXUDF]   = rd & (paddr_i == ADDR_RXDATA) & rx_empty;
        clr      = (wr && paddr_i == ADDR_IRQ_STAT) ? pwdata_i[IRQ_W-1:0] : '0;
        stat_d   = (stat_q & ~clr) | ev;
        irq_en_d = (wr && paddr_i == ADDR_IRQ_EN) ? pwdata_i[IRQ_W-1:0]
                                                 : irq_en_q;
    end

    always_ff @(posedge pclk_i) begin
        if (rst_i) begin
            en_q      <= 1'b0;
            div_q     <= MIN_DIV16;
            div_vld_q <= 1'b0;
            stat_q    <= '0;
            irq_en_q  <= '0;
            irq_q     <= 1'b0;
            pend_q    <= 1'b0;
        end else begin
            div_vld_q <= ctrl_wr;
            if (ctrl_wr) begin
                en_q  <= pwdata_i[CT_EN];
                div_q <= (wdiv < MIN_DIV16) ? MIN_DIV16 : wdiv;
            end
            stat_q   <= stat_d;
            irq_en_q <= irq_en_d;
            irq_q    <= |(stat_d & irq_en_d);
            if (tx_pop)     pend_q <= 1'b1;
            else if (eot_i) pend_q <= 1'b0;
        end
    end

    always_comb begin
        status = '0;
        status[ST_TX_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(tx_count);
        status[ST_RX_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(rx_count);
        status[ST_TX_EMPTY] = tx_empty;
        status[ST_TX_FULL]  = tx_full;
        status[ST_RX_EMPTY] = rx_empty;
        status[ST_RX_FULL]  = rx_full;
        status[ST_BUSY]     = stream_data_tx_vld_o | pend_q;
    end

    always_comb begin
        rdata = '0;
        if (rd) begin
            unique case (paddr_i)
                ADDR_RXDATA:   rdata = rx_empty ? '0 : 32'(rx_dout);
                ADDR_STATUS:   rdata = status;
                ADDR_CTRL:     rdata = {div_q, 15'd0, en_q};
                ADDR_IRQ_STAT: rdata = 32'(stat_q);
                ADDR_IRQ_EN:   rdata = 32'(irq_en_q);
                default:       rdata = '0;
            endcase
        end
    end

    assign prdata_o          = rdata;
    assign pready_o          = 1'b1;
    assign spi_clk_div_vld_o = div_vld_q;
    assign spi_clk_div_o     = div_q;
    assign irq_o             = irq_q;
endmodule

// File: tb/tb_apb_spi_rf_fifo.sv
// Directed bench for apb_spi_rf_fifo with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs sampled there.
module tb_apb_spi_rf_fifo;
    logic clk = 1'b0;
    logic rst;
    logic eot;
    logic div_vld;
    logic [15:0] div;
    logic irq;
    int total = 0;
    int passed = 0;
    int fails = 0;
    logic [31:0] d;
    logic [31:0] txq [$];

    apb_spi_rf_fifo_if #(.DW(32)) bus ();

    apb_spi_rf_fifo dut (
        .pclk_i(clk), .rst_i(rst),
        .psel_i(bus.psel), .penable_i(bus.penable), .pwrite_i(bus.pwrite),
        .paddr_i(bus.paddr), .pwdata_i(bus.pwdata), .prdata_o(bus.prdata),
        .pready_o(bus.pready),
        .spi_clk_div_vld_o(div_vld), .spi_clk_div_o(div), .eot_i(eot),
        .stream_data_tx_o(bus.tx_data), .stream_data_tx_vld_o(bus.tx_vld),
        .stream_data_tx_rdy_i(bus.tx_rdy),
        .stream_data_rx_i(bus.rx_data), .stream_data_rx_vld_i(bus.rx_vld),
        .stream_data_rx_rdy_o(bus.rx_rdy), .irq_o(irq)
    );

    always #5 clk = ~clk;

    always @(negedge clk)
        if (bus.tx_vld && bus.tx_rdy) txq.push_back(bus.tx_data);

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apb_wr(input logic [3:0] a, input logic [31:0] v);
        bus.psel = 1'b1; bus.pwrite = 1'b1; bus.paddr = a; bus.pwdata = v;
        bus.penable = 1'b0;
        tick();
        bus.penable = 1'b1;
        tick();
        bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    endtask

    task automatic apb_rd(input logic [3:0] a, output logic [31:0] v);
        bus.psel = 1'b1; bus.pwrite = 1'b0; bus.paddr = a;
        bus.penable = 1'b0;
        tick();
        bus.penable = 1'b1;
        #1 v = bus.prdata;
        @(posedge clk);
        #1;
        bus.psel = 1'b0; bus.penable = 1'b0;
    endtask

    task automatic rx_push(input logic [31:0] v);
        bus.rx_vld = 1'b1; bus.rx_data = v;
        tick();
        bus.rx_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1; eot = 1'b0;
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0;
        bus.paddr = '0; bus.pwdata = '0;
        bus.tx_rdy = 0; bus.rx_vld = 0; bus.rx_data = '0;
        tick(2);
        chk("rst_prdata", bus.prdata, 32'h0);
        chk("rst_txvld", 32'(bus.tx_vld), 32'h0);
        chk("rst_rxrdy", 32'(bus.rx_rdy), 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_divvld", 32'(div_vld), 32'h0);
        chk("rst_div", 32'(div), 32'h4);
        chk("rst_pready", 32'(bus.pready), 32'h1);
        rst = 1'b0;
        apb_rd(4'd2, d); chk("rst_status", d, 32'h0005_0000);
        apb_rd(4'd3, d); chk("rst_ctrl", d, 32'h0004_0000);
        apb_rd(4'd9, d); chk("unmapped_rd", d, 32'h0);

        // divider clamp and one-cycle update strobe
        apb_wr(4'd3, 32'h0002_0000);
        chk("div_clamp", 32'(div), 32'h4);
        chk("divvld_hi", 32'(div_vld), 32'h1);
        tick();
        chk("divvld_lo", 32'(div_vld), 32'h0);
        apb_wr(4'd3, 32'h0100_0000);
        chk("div_100", 32'(div), 32'h100);

        // three streamed bytes
        apb_wr(4'd3, 32'h0004_0001);
        bus.tx_rdy = 1'b1;
        txq.delete();
        repeat (3) apb_wr(4'd0, 32'h0000_00A5);
        tick(2);
        chk("a5_beats", 32'(txq.size()), 32'd3);
        for (int i = 0; i < txq.size(); i++) chk("a5_data", txq[i], 32'hA5);
        chk("a5_txvld", 32'(bus.tx_vld), 32'h0);
        apb_rd(4'd4, d); chk("a5_txempty", d, 32'h01);
        apb_rd(4'd2, d); chk("a5_busy", d, 32'h0015_0000);
        eot = 1'b1; tick(); eot = 1'b0;
        apb_rd(4'd2, d); chk("eot_idle", d, 32'h0005_0000);
        apb_rd(4'd4, d); chk("eot_irq", d, 32'h05);
        apb_wr(4'd4, 32'h1F);
        apb_rd(4'd4, d); chk("w1c", d, 32'h0);

        // overflow with EN=0, then push+pop on a full FIFO
        bus.tx_rdy = 1'b0;
        apb_wr(4'd3, 32'h0004_0000);
        for (int i = 1; i <= 9; i++) apb_wr(4'd0, 32'h10 + 32'(i));
        apb_rd(4'd2, d); chk("ovf_status", d, 32'h0006_0008);
        apb_rd(4'd4, d); chk("ovf_irq", d, 32'h08);
        apb_wr(4'd4, 32'h1F);
        apb_wr(4'd3, 32'h0004_0001);
        txq.delete();
        bus.psel = 1; bus.pwrite = 1; bus.paddr = 4'd0; bus.pwdata = 32'h99;
        tick();
        bus.penable = 1; bus.tx_rdy = 1;
        tick();
        bus.psel = 0; bus.penable = 0; bus.pwrite = 0; bus.tx_rdy = 0;
        apb_rd(4'd2, d); chk("pp_status", d, 32'h0014_0007);
        apb_rd(4'd4, d); chk("pp_irq", d, 32'h08);
        bus.tx_rdy = 1'b1;
        tick(10);
        chk("drain_n", 32'(txq.size()), 32'd8);
        for (int i = 0; i < txq.size(); i++)
            chk("drain_data", txq[i], 32'h11 + 32'(i));
        eot = 1'b1; tick(); eot = 1'b0;
        apb_wr(4'd4, 32'h1F);

        // TX flush; TXCLR reads back 0
        bus.tx_rdy = 1'b0;
        apb_wr(4'd3, 32'h0004_0000);
        apb_wr(4'd0, 32'h55);
        apb_wr(4'd0, 32'h66);
        apb_rd(4'd2, d); chk("fl_pre", d, 32'h0004_0002);
        apb_wr(4'd3, 32'h0004_0002);
        apb_rd(4'd2, d); chk("fl_post", d, 32'h0005_0000);
        apb_rd(4'd3, d); chk("fl_ctrl", d, 32'h0004_0000);

        // RX watermark, drain, underflow
        apb_wr(4'd3, 32'h0004_0001);
        apb_wr(4'd5, 32'h02);
        rx_push(32'h11); rx_push(32'h22); rx_push(32'h33);
        chk("wm_irq_lo", 32'(irq), 32'h0);
        rx_push(32'h44);
        chk("wm_irq_hi", 32'(irq), 32'h1);
        apb_rd(4'd2, d); chk("rx_status", d, 32'h0001_0400);
        apb_rd(4'd4, d); chk("rx_wm", d, 32'h02);
        apb_rd(4'd1, d); chk("rx0", d, 32'h11);
        apb_rd(4'd1, d); chk("rx1", d, 32'h22);
        apb_rd(4'd1, d); chk("rx2", d, 32'h33);
        apb_rd(4'd1, d); chk("rx3", d, 32'h44);
        apb_rd(4'd1, d); chk("rx_udf_data", d, 32'h0);
        apb_rd(4'd4, d); chk("rx_udf_irq", d, 32'h12);
        apb_rd(4'd5, d); chk("irq_en_rd", d, 32'h02);

        // reset in the middle of traffic
        txq.delete();
        apb_wr(4'd5, 32'h1F);
        apb_wr(4'd0, 32'h77);
        rx_push(32'hAB); rx_push(32'hCD);
        apb_wr(4'd3, 32'h0100_0001);
        chk("pre_irq", 32'(irq), 32'h1);
        chk("pre_txvld", 32'(bus.tx_vld), 32'h1);
        rst = 1'b1;
        tick();
        chk("mr_txvld", 32'(bus.tx_vld), 32'h0);
        chk("mr_rxrdy", 32'(bus.rx_rdy), 32'h0);
        chk("mr_irq", 32'(irq), 32'h0);
        chk("mr_div", 32'(div), 32'h4);
        chk("mr_divvld", 32'(div_vld), 32'h0);
        rst = 1'b0;
        bus.tx_rdy = 1'b1;
        apb_rd(4'd2, d); chk("mr_status", d, 32'h0005_0000);
        apb_rd(4'd4, d); chk("mr_irqstat", d, 32'h0);
        apb_wr(4'd3, 32'h0004_0001);
        tick(3);
        chk("mr_no_beat", 32'(txq.size()), 32'd0);
        apb_rd(4'd1, d); chk("mr_rx_empty", d, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
